// File: rtl/dmi_jtag_host.sv
`timescale 1ns/1ps
// Host-side JTAG scan engine for one DMI TAP: drives TCK/TMS/TDI from clk_i,
// runs IR, DR or TAP-reset sequences of up to MaxLen bits and returns captured TDO.
module dmi_jtag_host #(
    parameter int unsigned ClkDiv = 2,
    parameter int unsigned MaxLen = 64
) (
    input  logic              clk_i,
    input  logic              trst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_ir_i,
    input  logic              req_reset_i,
    input  logic [6:0]        req_len_i,
    input  logic [MaxLen-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [MaxLen-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    input  logic              tdo_i
);
    localparam int unsigned CW = $clog2(MaxLen + 7);
    localparam int unsigned BW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam int unsigned DW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    typedef enum logic [1:0] {INIT, IDLE, SCAN, RSP} state_t;
    state_t state_q, state_d;

    logic [DW-1:0]     div_q;
    logic [CW-1:0]     idx_q, len_q;
    logic [BW-1:0]     bit_q;
    logic              shift_q, ir_q, reset_q;
    logic [MaxLen-1:0] data_q, cap_q;

    logic              running, tick, rise, fall, last;
    logic [CW-1:0]     nxt, pre, last_idx, clamp_len;
    logic              nxt_tms, nxt_shift;
    logic [BW-1:0]     nxt_bit;

    always_comb begin
        if (req_len_i == 7'd0)              clamp_len = CW'(1);
        else if (int'(req_len_i) > MaxLen)  clamp_len = CW'(MaxLen);
        else                                clamp_len = CW'(req_len_i);
    end

    // TMS/TDI for the pulse after the current one; INIT and reset scans share one sequence
    always_comb begin
        running   = (state_q == INIT) || (state_q == SCAN);
        tick      = (div_q == DW'(ClkDiv - 1));
        rise      = running && tick && !tck_o;
        fall      = running && tick && tck_o;
        pre       = ir_q ? CW'(4) : CW'(3);
        last_idx  = reset_q ? CW'(5) : len_q + pre + CW'(1);
        last      = (idx_q == last_idx);
        nxt       = idx_q + CW'(1);
        nxt_tms   = 1'b0;
        nxt_shift = 1'b0;
        nxt_bit   = '0;
        if (reset_q) begin
            nxt_tms = (nxt < CW'(5));
        end else if (nxt < pre) begin
            nxt_tms = ir_q && (nxt < CW'(2));
        end else if (nxt < pre + len_q) begin
            nxt_shift = 1'b1;
            nxt_bit   = BW'(nxt - pre);
            nxt_tms   = (nxt == pre + len_q - CW'(1));
        end else begin
            nxt_tms = (nxt == pre + len_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (fall && last) state_d = IDLE;
            IDLE:    if (req_valid_i) state_d = SCAN;
            SCAN:    if (fall && last) state_d = RSP;
            RSP:     if (rsp_ready_i) state_d = IDLE;
            default: state_d = INIT;
        endcase
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RSP);
        busy_o      = running;
        rsp_data_o  = (state_q == RSP) ? cap_q : '0;
    end

    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) state_q <= INIT;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            div_q   <= '0;
            tck_o   <= 1'b0;
            tms_o   <= 1'b1;
            tdi_o   <= 1'b0;
            idx_q   <= '0;
            bit_q   <= '0;
            shift_q <= 1'b0;
            ir_q    <= 1'b0;
            reset_q <= 1'b1;
            len_q   <= CW'(1);
            data_q  <= '0;
            cap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        ir_q    <= req_ir_i;
                        reset_q <= req_reset_i;
                        len_q   <= clamp_len;
                        data_q  <= req_data_i;
                        cap_q   <= '0;
                        div_q   <= '0;
                        tck_o   <= 1'b0;
                        idx_q   <= '0;
                        tms_o   <= 1'b1;
                        tdi_o   <= 1'b0;
                        shift_q <= 1'b0;
                    end
                end
                INIT, SCAN: begin
                    if (tick) div_q <= '0;
                    else      div_q <= div_q + DW'(1);
                    if (rise) begin
                        tck_o <= 1'b1;
                        if (shift_q) cap_q[bit_q] <= tdo_i;
                    end
                    if (fall) begin
                        tck_o   <= 1'b0;
                        idx_q   <= nxt;
                        tms_o   <= nxt_tms;
                        tdi_o   <= nxt_shift && data_q[nxt_bit];
                        shift_q <= nxt_shift;
                        bit_q   <= nxt_bit;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmi_jtag_host.sv
`timescale 1ns/1ps
// Self-checking bench for dmi_jtag_host: a behavioural DMI TAP target, a pulse-list
// scoreboard checked every cycle, and directed scans with hand-computed results.
module tb_dmi_jtag_host;
    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        trst_ni = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_ir = 1'b0, req_reset = 1'b0;
    logic [6:0]  req_len = '0;
    logic [63:0] req_data = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic        busy, tck, tms, tdi;
    logic        tdo = 1'b0;

    int n_asserts = 0;
    int n_fail = 0;
    int pulses = 0;
    bit exp_tms[$];
    bit exp_tdi[$];
    logic [4:0] model_ir = 5'h01;

    always #5 clk = ~clk;

    dmi_jtag_host #(.ClkDiv(CLK_DIV), .MaxLen(64)) dut (
        .clk_i(clk), .trst_ni(trst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_ir_i(req_ir),
        .req_reset_i(req_reset), .req_len_i(req_len), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .busy_o(busy), .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_asserts++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Target DMI TAP: IDCODE (0x01, value 1) is 32 bits, every other IR selects a 1-bit bypass
    typedef enum int {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                      SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
    tap_t        tap = TLR;
    logic [4:0]  tap_ir = 5'h01;
    logic [4:0]  ir_sr = '0;
    logic [31:0] dr_sr = '0;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDR  : RTI;
            SDR:  return m ? SIR  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDR  : RTI;
            SIR:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap)
            TLR:  tap_ir = 5'h01;
            CIR:  ir_sr = 5'b00001;
            SHIR: ir_sr = {tdi, ir_sr[4:1]};
            UIR:  tap_ir = ir_sr;
            CDR:  dr_sr = (tap_ir == 5'h01) ? 32'h1 : 32'h0;
            SHDR: dr_sr = (tap_ir == 5'h01) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
            default: ;
        endcase
        tap = tap_next(tap, tms);
    end

    always @(negedge tck)
        tdo = (tap == SHIR) ? ir_sr[0] : (tap == SHDR) ? dr_sr[0] : 1'b0;

    // Per-cycle scoreboard: pulse shape, TMS/TDI per pulse, stability, idle levels
    bit prev_tck = 0, prev_tms = 1, prev_tdi = 0, prev_busy = 1;
    int lowcnt = 0, highcnt = 0;
    always @(negedge clk) begin
        if (!trst_ni) begin
            exp_tms.delete();
            exp_tdi.delete();
            lowcnt = 0;
            highcnt = 0;
        end else begin
            if (tck && !prev_tck) begin
                check("tck_low_phase", lowcnt, CLK_DIV);
                lowcnt = 0;
                highcnt = 1;
                pulses++;
                check("pulse_expected", exp_tms.size() != 0, 1);
                if (exp_tms.size() != 0) begin
                    check("tms_at_rise", tms, exp_tms.pop_front());
                    check("tdi_at_rise", tdi, exp_tdi.pop_front());
                end
            end else if (tck) begin
                check("tms_stable_high", tms, prev_tms);
                check("tdi_stable_high", tdi, prev_tdi);
                highcnt++;
            end else if (prev_tck) begin
                check("tck_high_phase", highcnt, CLK_DIV);
                highcnt = 0;
                lowcnt = busy ? 1 : 0;
            end else begin
                if (busy && prev_busy) begin
                    check("tms_stable_low", tms, prev_tms);
                    check("tdi_stable_low", tdi, prev_tdi);
                end
                lowcnt = busy ? lowcnt + 1 : 0;
            end
            if (!busy) check("tck_idle_low", tck, 1'b0);
            if (req_ready) check("idle_tms", tms, 1'b0);
        end
        prev_tck = tck;
        prev_tms = tms;
        prev_tdi = tdi;
        prev_busy = busy;
    end

    task automatic push(input bit m, input bit d);
        exp_tms.push_back(m);
        exp_tdi.push_back(d);
    endtask

    task automatic push_pulses(input bit ir, input bit rst, input int el, input logic [63:0] d);
        if (rst) begin
            for (int i = 0; i < 6; i++) push(i < 5, 1'b0);
        end else begin
            if (ir) begin push(1, 0); push(1, 0); push(0, 0); push(0, 0); end
            else    begin push(1, 0); push(0, 0); push(0, 0); end
            for (int i = 0; i < el; i++) push(i == el - 1, d[i]);
            push(1, 0);
            push(0, 0);
        end
    endtask

    // Abstract view of the target: what comes out of TDO for a given scan
    task automatic model_scan(input bit ir, input bit rst, input int el, input logic [63:0] d,
                              output logic [63:0] out);
        logic [4:0]  s5;
        logic [31:0] s32;
        logic        s1;
        out = '0;
        if (rst) begin
            model_ir = 5'h01;
        end else if (ir) begin
            s5 = 5'b00001;
            for (int i = 0; i < el; i++) begin out[i] = s5[0]; s5 = {d[i], s5[4:1]}; end
            model_ir = s5;
        end else if (model_ir == 5'h01) begin
            s32 = 32'h1;
            for (int i = 0; i < el; i++) begin out[i] = s32[0]; s32 = {d[i], s32[31:1]}; end
        end else begin
            s1 = 1'b0;
            for (int i = 0; i < el; i++) begin out[i] = s1; s1 = d[i]; end
        end
    endtask

    task automatic wait_ready();
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            if (req_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check("ready_wait", ok, 1);
    endtask

    task automatic issue(input bit ir, input bit rst, input int len, input logic [63:0] d,
                         output int n, output logic [63:0] want);
        int el;
        el = (len == 0) ? 1 : (len > 64) ? 64 : len;
        wait_ready();
        check("queue_empty_before", exp_tms.size(), 0);
        req_valid = 1; req_ir = ir; req_reset = rst; req_len = 7'(len); req_data = d;
        push_pulses(ir, rst, el, d);
        n = exp_tms.size();
        model_scan(ir, rst, el, d, want);
        pulses = 0;
        @(posedge clk); #1;
        req_valid = 0; req_len = 7'h7f; req_data = '1; req_ir = ~ir;
    endtask

    task automatic do_scan(input bit ir, input bit rst, input int len, input logic [63:0] d,
                           input int hold, output logic [63:0] got);
        int n, lat;
        logic [63:0] want;
        issue(ir, rst, len, d, n, want);
        lat = 1;
        while (!rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
        check("latency", lat, n * 2 * CLK_DIV + 1);
        check("pulse_count", pulses, n);
        check("rsp_data", rsp_data, want);
        check("busy_in_rsp", busy, 1'b0);
        check("ready_in_rsp", req_ready, 1'b0);
        check("tap_in_rti", tap == RTI, 1);
        got = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1'b1);
            check("hold_data", rsp_data, got);
            check("hold_ready", req_ready, 1'b0);
            check("hold_tck", tck, 1'b0);
            check("hold_pulses", pulses, n);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        check("ready_after_rsp", req_ready, 1'b1);
        check("valid_after_rsp", rsp_valid, 1'b0);
    endtask

    task automatic reset_and_init();
        @(posedge clk); #2;
        trst_ni = 0;
        #1;
        check("rst_tck", tck, 1'b0);
        check("rst_tms", tms, 1'b1);
        check("rst_tdi", tdi, 1'b0);
        check("rst_ready", req_ready, 1'b0);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_data", rsp_data, 64'h0);
        check("rst_busy", busy, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        trst_ni = 1;
        pulses = 0;
        push_pulses(0, 1, 6, '0);
        model_ir = 5'h01;
        wait_ready();
        check("init_pulses", pulses, 6);
        check("init_queue_empty", exp_tms.size(), 0);
        check("init_busy", busy, 1'b0);
        check("init_tck", tck, 1'b0);
        check("init_tap_rti", tap == RTI, 1);
    endtask

    initial begin
        logic [63:0] got;
        int n;
        logic [63:0] want;

        reset_and_init();

        do_scan(1, 0, 5, 64'h11, 0, got);
        check("ir11_rsp_lit", got, 64'h01);
        check("ir11_pulses_lit", pulses, 11);
        check("ir11_tap_ir", tap_ir, 5'h11);

        do_scan(0, 1, 17, 64'hFFFF, 0, got);
        check("tapreset_rsp_lit", got, 64'h0);
        check("tapreset_tap_ir", tap_ir, 5'h01);

        do_scan(0, 0, 32, 64'h0, 0, got);
        check("idcode_rsp_lit", got, 64'h1);
        check("idcode_pulses_lit", pulses, 37);

        do_scan(1, 0, 5, 64'h1F, 0, got);
        check("ir1f_tap_ir", tap_ir, 5'h1F);
        do_scan(0, 0, 8, 64'hA5, 10, got);
        check("bypass_rsp_lit", got, 64'h4A);

        do_scan(1, 0, 5, 64'h01, 0, got);
        do_scan(0, 0, 100, 64'hDEADBEEF_CAFEF00D, 0, got);
        check("clamp64_rsp_lit", got, 64'hCAFEF00D_00000001);
        check("clamp64_pulses_lit", pulses, 69);

        issue(0, 0, 41, 64'h1_2345_6789_ABCD, n, want);
        repeat (100) @(posedge clk);
        check("midscan_busy", busy, 1'b1);
        reset_and_init();

        do_scan(0, 0, 0, 64'h0, 0, got);
        check("len0_rsp_lit", got, 64'h1);
        check("len0_pulses_lit", pulses, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dmi_jtag_host.md
# dmi_jtag_host

JTAG host-side scan engine: the driving end of the DMI JTAG TAP. It generates TCK/TMS/TDI from a system clock, walks the target TAP through IR or DR scans of up to 64 bits, and returns the TDO bits captured during the shift. It sits between a debug-transport front end (request/response handshake) and the JTAG pins of one DMI TAP.

## Interface
- ClkDiv, 2, TCK half-period in clk_i cycles; must be ≥1. The TCK period is 2*ClkDiv clk_i cycles.
- MaxLen, 64, maximum scan length in bits; the width of the data buses.
- clk_i  in  1  system clock; all logic is on posedge.
- trst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  a scan request is presented.
- req_ready_o  out  1  the engine is idle and accepts a request.
- req_ir_i  in  1  1 = IR scan, 0 = DR scan.
- req_reset_i  in  1  1 = drive the TAP to Test-Logic-Reset and then Run-Test/Idle. Overrides req_ir_i; len and data are ignored.
- req_len_i  in  7  number of shift bits.
- req_data_i  in  MaxLen  TDI bits, LSB shifted first.
- rsp_valid_o  out  1  response is available.
- rsp_ready_i  in  1  response is consumed.
- rsp_data_o  out  MaxLen  captured TDO bits, LSB = first bit. Bits at or above len are 0.
- busy_o  out  1  a scan or init sequence is in progress.
- tck_o  out  1  JTAG TCK.
- tms_o  out  1  JTAG TMS.
- tdi_o  out  1  JTAG TDI.
- tdo_i  in  1  JTAG TDO from the target. It changes on the TCK falling edge.

## Operation
- FSM states: INIT, IDLE, SCAN, RSP. The reset state is INIT.
- INIT: drives the TMS sequence 1,1,1,1,1,0 (6 TCK pulses), leaving the TAP in Run-Test/Idle. Then goes to IDLE.
- IDLE:
  - req_ready_o = 1. tck_o is held low, tms_o = 0.
  - On req_valid_i && req_ready_o, the engine latches ir, reset, len and data, clears the capture register, and goes to SCAN.
- Length clamping: len 0 → 1; len > MaxLen → MaxLen.
- SCAN TMS sequences, one entry per TCK pulse, starting from Run-Test/Idle:
  - IR: 1,1,0,0, then len shift bits, then 1,0. The shift bits are 0 except the last, which is 1. Total len+6 pulses.
  - DR: 1,0,0, then len shift bits, then 1,0. Shift bits are as for IR. Total len+5 pulses.
  - Reset: 1,1,1,1,1,0. Total 6 pulses; the response data is 0.
- tdi_o carries data[i] during shift pulse i and is 0 otherwise.
- On the rising edge of shift pulse i, the engine samples tdo_i into capture[i].
- After the final pulse the FSM goes to RSP. rsp_valid_o = 1 and rsp_data_o holds the capture register.
- RSP: hold until rsp_ready_i, then return to IDLE. rsp_data_o is held stable while rsp_valid_o = 1. No new request is accepted in RSP.
- busy_o = 1 in INIT and SCAN, else 0.
- The internal TAP-state mirror is always Run-Test/Idle on return to IDLE.

## Timing
- Reset values:
  - State: INIT.
  - tck_o = 0, tms_o = 1, tdi_o = 0.
  - req_ready_o = 0, rsp_valid_o = 0, rsp_data_o = 0.
  - busy_o = 1.
- A divider counter counts 0..ClkDiv-1. Each TCK pulse is ClkDiv cycles low followed by ClkDiv cycles high.
- The first TCK low phase starts the cycle after request acceptance (or after reset release). tck_o, tms_o and tdi_o are all registered.
- tms_o and tdi_o change only in the cycle where tck_o goes 1→0, or at the start of the first low phase. They are stable across every rising edge.
- tdo_i is sampled in the clk_i cycle where tck_o goes 0→1, i.e. the same edge at which the target shifts.
- Latency from acceptance to rsp_valid_o:
  - IR: (len+6)*2*ClkDiv + 1 cycles.
  - DR: (len+5)*2*ClkDiv + 1 cycles.
  - Reset: 6*2*ClkDiv + 1 cycles.
- rsp_valid_o to req_ready_o: 1 cycle after the rsp handshake.
- Back-to-back: a request presented in the same cycle req_ready_o rises is accepted.
- A response is never dropped: there is no new scan until the RSP handshake completes.
- trst_ni low at any time, including mid-scan, forces all reset values immediately (asynchronous). tck_o goes low at once. On release, INIT reruns in full.
- Request inputs are ignored outside IDLE.

## Test plan
- Reset release, ClkDiv=2: 6 TCK pulses of period 4 clk, TMS 1,1,1,1,1,0; then req_ready_o=1, busy_o=0, tck_o held low.
- IR scan, len 5, data 0x11, against a DMI TAP model: TDI bits 1,0,0,0,1; 11 TCK pulses; rsp_data_o=0x01 (capture pattern); the TAP IR becomes 0x11.
- After reset, DR scan len 32 (IR defaults to IDCODE, IdcodeValue 0x00000001): rsp_data_o=0x00000001; 37 TCK pulses.
- IR=0x1F, then DR len 8, data 0xA5: bypass delays the data by one bit, so rsp_data_o=0x4A.
- rsp_ready_i held low 10 cycles after a scan: rsp_valid_o and rsp_data_o stay stable, req_ready_o=0, tck_o stays low, no pulses.
- trst_ni asserted in the middle of a 41-bit DR scan: all outputs take reset values in the same cycle. After release, 6 INIT pulses (TMS 1,1,1,1,1,0) occur before req_ready_o=1. A following len-0 DR scan is clamped to 1 bit.
